// File: rtl/switch_frame_scheduler.sv
// Round-robin scheduler for the shared serial switch link.
// Each frame is FRAME_BITS data slots (MSB first) followed by GAP_CYCLES
// idle slots, matching the receiver's shift-then-latch cadence. Arbitration
// happens only in the final gap slot. With no winner, the last committed
// frame is resent so the receiver's latched outputs stay put.
module switch_frame_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int FRAME_BITS = 21,
  parameter int GAP_CYCLES = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*FRAME_BITS-1:0] req_data,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          serial_bit,
  output logic                          frame_start,
  output logic [$clog2(NUM_REQ)-1:0]    cur_src,
  output logic                          repeat_frame
);

  localparam int SLOTS  = FRAME_BITS + GAP_CYCLES;
  localparam int SLOT_W = $clog2(SLOTS);
  localparam int BIT_W  = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int IDX_W  = $clog2(NUM_REQ);

  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(SLOTS - 1);
  localparam logic [SLOT_W-1:0] SLOT_GAP0  = SLOT_W'(FRAME_BITS);
  localparam logic [BIT_W-1:0]  BIT_MSB    = BIT_W'(FRAME_BITS - 1);
  localparam logic [IDX_W:0]    NUM_REQ_X  = (IDX_W + 1)'(NUM_REQ);

  logic [SLOT_W-1:0]     slot_q,    slot_d;
  logic [FRAME_BITS-1:0] shreg_q,   shreg_d;
  logic [FRAME_BITS-1:0] last_q,    last_d;
  logic [IDX_W-1:0]      rr_ptr_q,  rr_ptr_d;
  logic [IDX_W-1:0]      cur_src_q, cur_src_d;
  logic                  repeat_q,  repeat_d;

  logic                  win_vld;
  logic [IDX_W-1:0]      win_idx;
  logic [IDX_W:0]        cand_x;
  logic [IDX_W-1:0]      cand;
  logic [IDX_W:0]        rr_next_x;
  logic [FRAME_BITS-1:0] win_word;
  logic [BIT_W-1:0]      bit_pos;

  // Round-robin search from rr_ptr upward with wrap; only live in the last gap slot.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand_x  = '0;
    cand    = '0;
    grant   = '0;
    if (slot_q == SLOT_LAST) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cand_x = {1'b0, rr_ptr_q} + (IDX_W + 1)'(i);
        if (cand_x >= NUM_REQ_X) begin
          cand_x = cand_x - NUM_REQ_X;
        end
        cand = cand_x[IDX_W-1:0];
        if (!win_vld && req[cand]) begin
          win_vld = 1'b1;
          win_idx = cand;
        end
      end
    end
    if (win_vld) begin
      grant[win_idx] = 1'b1;
    end
  end

  assign win_word = req_data[win_idx*FRAME_BITS +: FRAME_BITS];

  // Slot counter plus frame commit at the end of the last gap slot.
  always_comb begin
    slot_d    = (slot_q == SLOT_LAST) ? '0 : slot_q + SLOT_W'(1);
    shreg_d   = shreg_q;
    last_d    = last_q;
    rr_ptr_d  = rr_ptr_q;
    cur_src_d = cur_src_q;
    repeat_d  = repeat_q;
    rr_next_x = {1'b0, win_idx} + (IDX_W + 1)'(1);
    if (rr_next_x >= NUM_REQ_X) begin
      rr_next_x = '0;
    end
    if (slot_q == SLOT_LAST) begin
      if (win_vld) begin
        shreg_d   = win_word;
        last_d    = win_word;
        cur_src_d = win_idx;
        rr_ptr_d  = rr_next_x[IDX_W-1:0];
        repeat_d  = 1'b0;
      end else begin
        // Replay keeps the receiver's latched outputs unchanged.
        shreg_d  = last_q;
        repeat_d = 1'b1;
      end
    end
  end

  // State registers; reset may land mid-frame and restarts at slot 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_q    <= '0;
      shreg_q   <= '0;
      last_q    <= '0;
      rr_ptr_q  <= '0;
      cur_src_q <= '0;
      repeat_q  <= 1'b1;
    end else begin
      slot_q    <= slot_d;
      shreg_q   <= shreg_d;
      last_q    <= last_d;
      rr_ptr_q  <= rr_ptr_d;
      cur_src_q <= cur_src_d;
      repeat_q  <= repeat_d;
    end
  end

  // Slot k of a data phase carries bit FRAME_BITS-1-k; gap slots drive 0.
  assign bit_pos      = BIT_MSB - slot_q[BIT_W-1:0];
  assign serial_bit   = (slot_q < SLOT_GAP0) ? shreg_q[bit_pos] : 1'b0;
  assign frame_start  = (slot_q == '0);
  assign cur_src      = cur_src_q;
  assign repeat_frame = repeat_q;

endmodule

// File: tb/tb_switch_frame_scheduler.sv
// Directed bench for switch_frame_scheduler: a table of per-frame
// arbitration vectors plus hand-written reset and withdraw sequences.
module tb_switch_frame_scheduler;

  localparam int NR = 4;
  localparam int FB = 21;
  localparam int SL = 22;

  logic              clk;
  logic              rst_n;
  logic [NR-1:0]     req;
  logic [NR*FB-1:0]  req_data;
  logic [NR-1:0]     grant;
  logic              serial_bit;
  logic              frame_start;
  logic [1:0]        cur_src;
  logic              repeat_frame;

  switch_frame_scheduler #(.NUM_REQ(NR), .FRAME_BITS(FB), .GAP_CYCLES(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .req_data     (req_data),
    .grant        (grant),
    .serial_bit   (serial_bit),
    .frame_start  (frame_start),
    .cur_src      (cur_src),
    .repeat_frame (repeat_frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cur_slot = 0;

  logic [FB-1:0] words [NR];

  typedef struct {
    logic [NR-1:0] req;
    logic [NR-1:0] gnt;
    logic [1:0]    src;
    logic          rep;
    logic [FB-1:0] word;
  } vec_t;

  localparam int NV = 14;
  vec_t tbl [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cur_slot = (cur_slot + 1) % SL;
  endtask

  task automatic load_data();
    for (int i = 0; i < NR; i++) req_data[i*FB +: FB] = words[i];
  endtask

  // Starts in slot 0, samples slots 0..FB-1, ends in the gap slot.
  task automatic capture_frame(input string tag, output logic [FB-1:0] w);
    logic fs_bad;
    logic g_bad;
    w      = '0;
    fs_bad = 1'b0;
    g_bad  = 1'b0;
    for (int k = 0; k < FB; k++) begin
      w = {w[FB-2:0], serial_bit};
      if (frame_start !== (k == 0)) fs_bad = 1'b1;
      if (grant !== '0) g_bad = 1'b1;
      step();
    end
    check({tag, " frame_start"}, 32'(fs_bad), 32'd0);
    check({tag, " grant_idle"}, 32'(g_bad), 32'd0);
    check({tag, " gap_bit"}, 32'(serial_bit), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [FB-1:0] w;

    words[0] = 21'h1ABCDE;
    words[1] = 21'h0F0F0F;
    words[2] = 21'h155555;
    words[3] = 21'h0AAAAA;

    tbl[0]  = '{4'b0000, 4'b0000, 2'd0, 1'b1, 21'h0};
    tbl[1]  = '{4'b0000, 4'b0000, 2'd0, 1'b1, 21'h0};
    tbl[2]  = '{4'b0001, 4'b0001, 2'd0, 1'b0, 21'h1ABCDE};
    tbl[3]  = '{4'b1111, 4'b0010, 2'd1, 1'b0, 21'h0F0F0F};
    tbl[4]  = '{4'b1111, 4'b0100, 2'd2, 1'b0, 21'h155555};
    tbl[5]  = '{4'b1111, 4'b1000, 2'd3, 1'b0, 21'h0AAAAA};
    tbl[6]  = '{4'b1111, 4'b0001, 2'd0, 1'b0, 21'h1ABCDE};
    tbl[7]  = '{4'b0100, 4'b0100, 2'd2, 1'b0, 21'h155555};
    tbl[8]  = '{4'b0000, 4'b0000, 2'd2, 1'b1, 21'h155555};
    tbl[9]  = '{4'b0000, 4'b0000, 2'd2, 1'b1, 21'h155555};
    tbl[10] = '{4'b0000, 4'b0000, 2'd2, 1'b1, 21'h155555};
    tbl[11] = '{4'b1001, 4'b1000, 2'd3, 1'b0, 21'h0AAAAA};
    tbl[12] = '{4'b0110, 4'b0010, 2'd1, 1'b0, 21'h0F0F0F};
    tbl[13] = '{4'b0001, 4'b0001, 2'd0, 1'b0, 21'h1ABCDE};

    req = '0;
    load_data();
    rst_n = 1'b0;
    step();
    step();
    cur_slot = 0;
    check("rst frame_start", 32'(frame_start), 32'd1);
    check("rst serial_bit", 32'(serial_bit), 32'd0);
    check("rst repeat_frame", 32'(repeat_frame), 32'd1);
    check("rst grant", 32'(grant), 32'd0);
    check("rst cur_src", 32'(cur_src), 32'd0);
    rst_n = 1'b1;

    capture_frame("post_rst", w);
    check("post_rst word", 32'(w), 32'd0);

    // Table: each entry is one arbitration slot followed by one full frame.
    for (int e = 0; e < NV; e++) begin
      load_data();
      req = tbl[e].req;
      #1;
      check($sformatf("vec%0d grant", e), 32'(grant), 32'(tbl[e].gnt));
      step();
      req = '0;
      req_data = ~req_data;
      check($sformatf("vec%0d cur_src", e), 32'(cur_src), 32'(tbl[e].src));
      check($sformatf("vec%0d repeat", e), 32'(repeat_frame), 32'(tbl[e].rep));
      capture_frame($sformatf("vec%0d", e), w);
      check($sformatf("vec%0d word", e), 32'(w), 32'(tbl[e].word));
    end
    load_data();

    // Reset in slot 10 of a replayed frame while requester 1 waits.
    step();
    req = 4'b0010;
    while (cur_slot != 10) step();
    rst_n = 1'b0;
    step();
    cur_slot = 0;
    check("midrst frame_start", 32'(frame_start), 32'd1);
    check("midrst serial_bit", 32'(serial_bit), 32'd0);
    check("midrst repeat", 32'(repeat_frame), 32'd1);
    check("midrst cur_src", 32'(cur_src), 32'd0);
    check("midrst grant", 32'(grant), 32'd0);
    rst_n = 1'b1;
    capture_frame("midrst", w);
    check("midrst word", 32'(w), 32'd0);
    check("midrst pending grant", 32'(grant), 32'b0010);
    step();
    req = '0;
    check("midrst cur_src after", 32'(cur_src), 32'd1);
    check("midrst repeat after", 32'(repeat_frame), 32'd0);
    capture_frame("midrst_gnt", w);
    check("midrst_gnt word", 32'(w), 32'(words[1]));

    // Request raised in slot 5 and withdrawn in slot 15 never wins.
    check("wd pre grant", 32'(grant), 32'd0);
    step();
    while (cur_slot != 5) step();
    req = 4'b0010;
    while (cur_slot != 15) step();
    req = '0;
    while (cur_slot != 21) step();
    check("wd grant", 32'(grant), 32'd0);
    step();
    check("wd repeat", 32'(repeat_frame), 32'd1);
    check("wd cur_src", 32'(cur_src), 32'd1);
    capture_frame("wd", w);
    check("wd word", 32'(w), 32'(words[1]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/switch_frame_scheduler.md
Name: switch_frame_scheduler

Overview:
Shares the single serial switch link between NUM_REQ requesters. Each requester offers a FRAME_BITS-wide parallel word. The block arbitrates round-robin, serializes the winner MSB-first, and inserts one gap slot per frame so that the downstream serial-to-parallel switch receiver (21 shift cycles, then 1 latch cycle) stays frame-aligned. When no requester is pending, the last committed frame is retransmitted so the latched switch outputs never change spuriously.

Parameters:
NUM_REQ, 4, number of requesters (≥2).
FRAME_BITS, 21, bits per frame; must equal the receiver shift length.
GAP_CYCLES, 1, idle slots per frame; must equal the receiver latch slots.

Ports:
clk  input  1  system clock, all logic on rising edge.
rst_n  input  1  synchronous active-low reset.
req  input  NUM_REQ  request vector; bit i = requester i has a frame pending.
req_data  input  NUM_REQ*FRAME_BITS  flat frame words; requester i occupies bits [i*FRAME_BITS +: FRAME_BITS].
grant  output  NUM_REQ  one-hot, one-cycle acknowledge; the winner's word is captured in this cycle.
serial_bit  output  1  serial data to the receiver input_bit.
frame_start  output  1  high during slot 0 of every frame.
cur_src  output  clog2(NUM_REQ)  source index of the frame currently on the wire.
repeat_frame  output  1  high for the whole frame when it is a retransmission (no grant).

Behaviour:
- Slot counter runs 0..FRAME_BITS+GAP_CYCLES-1 (0..21), then wraps to 0. It is free-running and never stalls.
- Slots 0..FRAME_BITS-1 are data slots. In slot k, serial_bit = shreg[FRAME_BITS-1-k] (MSB first), so the receiver's first-shifted bit ends in its bit 20.
- Slots ≥ FRAME_BITS are gap slots, with serial_bit = 0.
- Arbitration happens only in the last gap slot (slot 21):
  - Search starts at rr_ptr and proceeds upward with wrap.
  - The first set req bit wins.
  - grant[winner] = 1 for that single cycle. grant is combinational from registered slot, rr_ptr and live req, and is 0 in all other slots.
- At the clock edge ending slot 21 with a winner:
  - shreg <= winner's word; last_frame <= winner's word; cur_src <= winner.
  - rr_ptr <= (winner+1) mod NUM_REQ.
  - repeat_frame <= 0.
- At the same edge with no winner: shreg <= last_frame; cur_src and rr_ptr unchanged; repeat_frame <= 1.
- Requester protocol:
  - Hold req and req_data stable until grant is seen. Deasserting req before slot 21 withdraws the request without error.
  - A requester may hold req continuously; it is then served once every NUM_REQ frames under full contention.
- Latency: a req first sampled in slot 21 is granted in that same cycle, and its MSB appears on serial_bit in the next cycle (slot 0).
- Worst-case wait under full load is NUM_REQ*(FRAME_BITS+GAP_CYCLES) = 88 cycles.
- req_data changing after grant has no effect on the frame in flight.
- Reset (rst_n=0 at an edge, including mid-frame), next cycle:
  - slot = 0; shreg = 0; last_frame = 0; rr_ptr = 0; cur_src = 0.
  - repeat_frame = 1; grant = 0; serial_bit = 0; frame_start = 1.
  - The downstream receiver must be reset or powered up on the same edge for alignment.
- The first arbitration after reset occurs in the first slot 21. The first frame after reset is all-zero.
- frame_start is registered-equivalent: 1 exactly when slot==0.

Test Plan:
- Reset then idle 3 frames → serial_bit constant 0, frame_start every 22 cycles, repeat_frame=1, grant never asserted.
- req=4'b0001, data0=21'h1ABCDE, held until grant → grant=4'b0001 in slot 21. The next 21 serial_bit cycles are 1,1,0,1,0,1,0,1,1,1,1,0,0,1,1,0,1,1,1,1,0, then 0 in the gap. Receiver out = {data[12:5],data[20:13],data[4:0]} of 21'h1ABCDE.
- req=4'b1111 held 4 frames → grants 0001,0010,0100,1000 in successive slot-21 cycles; cur_src 0,1,2,3.
- Grant requester 2 with 21'h155555, then drop all req → the next 3 frames resend 21'h155555 with repeat_frame=1; rr_ptr=3, so a new req=4'b1001 is granted to 3.
- rst_n pulsed low in slot 10 of an active frame → next cycle slot 0, serial_bit=0, shreg cleared; the pending req is granted at the following slot 21.
- req[1] asserted in slot 5 and dropped in slot 15 → no grant; the frame repeats.
